// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-requester round-robin bus arbiter with hold watchdog and turnaround gap
module bus_arbiter #(
    parameter int HOLD_MAX = 64,
    parameter int TURN_CYC = 1
) (
    input  logic       BUS_CLK,
    input  logic       RST,
    input  logic [3:0] BR,
    input  logic       ACK,
    output logic [3:0] BG,
    output logic [1:0] OWNER,
    output logic       OWNER_VLD,
    output logic       BUS_IDLE,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        TURN  = 3'b100
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(HOLD_MAX - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] mask;
    logic [7:0] wdog;
    logic [1:0] turn_cnt;

    logic [3:0] eligible;
    logic       any_eligible;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       owner_req;
    logic       timeout_hit;

    assign eligible     = BR & ~mask;
    assign any_eligible = |eligible;
    assign owner_req    = BR[OWNER];
    assign timeout_hit  = (wdog == WDOG_LAST) && !ACK;

    // Rotating search starting at ptr: first eligible requester wins.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            mask        <= 4'd0;
            wdog        <= 8'd0;
            turn_cnt    <= 2'd0;
            BG          <= 4'd0;
            OWNER       <= 2'd0;
            OWNER_VLD   <= 1'b0;
            BUS_IDLE    <= 1'b1;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            TIMEOUT_ERR <= 1'b0;
            // A low request always forgives an earlier revoke.
            mask        <= mask & BR;
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state     <= GRANT;
                        BG        <= 4'b0001 << winner;
                        OWNER     <= winner;
                        OWNER_VLD <= 1'b1;
                        BUS_IDLE  <= 1'b0;
                        ptr       <= winner + 2'd1;
                        wdog      <= 8'd0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        // Release wins over a timeout firing on the same edge.
                        state     <= TURN;
                        BG        <= 4'd0;
                        OWNER_VLD <= 1'b0;
                        turn_cnt  <= 2'd0;
                    end else if (timeout_hit) begin
                        state       <= TURN;
                        BG          <= 4'd0;
                        OWNER_VLD   <= 1'b0;
                        turn_cnt    <= 2'd0;
                        TIMEOUT_ERR <= 1'b1;
                        mask        <= (mask & BR) | (4'b0001 << OWNER);
                    end else if (ACK) begin
                        wdog <= 8'd0;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        if (any_eligible) begin
                            state     <= GRANT;
                            BG        <= 4'b0001 << winner;
                            OWNER     <= winner;
                            OWNER_VLD <= 1'b1;
                            ptr       <= winner + 2'd1;
                            wdog      <= 8'd0;
                        end else begin
                            state    <= IDLE;
                            BUS_IDLE <= 1'b1;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    BG        <= 4'd0;
                    OWNER_VLD <= 1'b0;
                    BUS_IDLE  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

    logic       BUS_CLK;
    logic       RST;
    logic [3:0] BR;
    logic       ACK;
    logic [3:0] BG;
    logic [1:0] OWNER;
    logic       OWNER_VLD;
    logic       BUS_IDLE;
    logic       TIMEOUT_ERR;

    int tests;
    int fails;

    bus_arbiter #(.HOLD_MAX(64), .TURN_CYC(1)) dut (
        .BUS_CLK    (BUS_CLK),
        .RST        (RST),
        .BR         (BR),
        .ACK        (ACK),
        .BG         (BG),
        .OWNER      (OWNER),
        .OWNER_VLD  (OWNER_VLD),
        .BUS_IDLE   (BUS_IDLE),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    task automatic tick;
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        BR  = 4'd0;
        ACK = 1'b0;
        tick();
        tick();
        tests++; if (BG !== 4'd0) begin fails++; $display("FAIL reset_bg: got %b expected %b", BG, 4'd0); end
        tests++; if (OWNER !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d expected %0d", OWNER, 0); end
        tests++; if (OWNER_VLD !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b expected %b", OWNER_VLD, 1'b0); end
        tests++; if (BUS_IDLE !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected %b", BUS_IDLE, 1'b1); end
        tests++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL reset_tmo: got %b expected %b", TIMEOUT_ERR, 1'b0); end
        RST = 1'b0;
        tick();
        tick();
        tests++; if (BG !== 4'd0 || BUS_IDLE !== 1'b1) begin fails++; $display("FAIL idle_no_req: got bg=%b idle=%b expected bg=0000 idle=1", BG, BUS_IDLE); end
    endtask

    task automatic test_basic_grant;
        BR = 4'b0110;
        tick();
        tests++; if (BG !== 4'b0010) begin fails++; $display("FAIL basic_bg1: got %b expected %b", BG, 4'b0010); end
        tests++; if (OWNER !== 2'd1 || OWNER_VLD !== 1'b1) begin fails++; $display("FAIL basic_owner1: got %0d/%b expected 1/1", OWNER, OWNER_VLD); end
        tests++; if (dut.ptr !== 2'd2) begin fails++; $display("FAIL basic_ptr: got %0d expected %0d", dut.ptr, 2); end
        tests++; if (BUS_IDLE !== 1'b0) begin fails++; $display("FAIL basic_idle: got %b expected %b", BUS_IDLE, 1'b0); end
        tick();
        tick();
        tests++; if (BG !== 4'b0010) begin fails++; $display("FAIL basic_hold: got %b expected %b", BG, 4'b0010); end
        BR = 4'b0100;
        tick();
        tests++; if (BG !== 4'd0 || OWNER_VLD !== 1'b0) begin fails++; $display("FAIL basic_gap: got %b/%b expected 0000/0", BG, OWNER_VLD); end
        tests++; if (OWNER !== 2'd1) begin fails++; $display("FAIL basic_owner_keep: got %0d expected %0d", OWNER, 1); end
        tick();
        tests++; if (BG !== 4'b0100 || OWNER !== 2'd2) begin fails++; $display("FAIL basic_bg2: got %b/%0d expected 0100/2", BG, OWNER); end
        tests++; if (dut.ptr !== 2'd3) begin fails++; $display("FAIL basic_ptr2: got %0d expected %0d", dut.ptr, 3); end
        BR = 4'd0;
        tick();
        tick();
        tests++; if (BG !== 4'd0 || BUS_IDLE !== 1'b1) begin fails++; $display("FAIL basic_back_idle: got %b/%b expected 0000/1", BG, BUS_IDLE); end
    endtask

    task automatic test_round_robin;
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_bg;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        BR  = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_bg = 4'b0001 << seq[i];
            for (int c = 0; c < 3; c++) begin
                tests++; if (BG !== exp_bg) begin fails++; $display("FAIL rr_grant%0d_c%0d: got %b expected %b", i, c, BG, exp_bg); end
                if (c < 2) tick();
            end
            BR = 4'b1111 & ~exp_bg;
            tick();
            tests++; if (BG !== 4'd0) begin fails++; $display("FAIL rr_gap%0d: got %b expected %b", i, BG, 4'd0); end
            BR = (i == 4) ? 4'd0 : 4'b1111;
            tick();
        end
        tests++; if (BG !== 4'd0 || BUS_IDLE !== 1'b1) begin fails++; $display("FAIL rr_end_idle: got %b/%b expected 0000/1", BG, BUS_IDLE); end
    endtask

    task automatic test_timeout;
        int n;
        ACK = 1'b0;
        BR  = 4'b1000;
        tick();
        n = 0;
        while (BG === 4'b1000 && n < 300) begin
            n++;
            tick();
        end
        tests++; if (n != 64) begin fails++; $display("FAIL tmo_hold_cycles: got %0d expected %0d", n, 64); end
        tests++; if (TIMEOUT_ERR !== 1'b1) begin fails++; $display("FAIL tmo_pulse: got %b expected %b", TIMEOUT_ERR, 1'b1); end
        tests++; if (dut.mask !== 4'b1000) begin fails++; $display("FAIL tmo_mask: got %b expected %b", dut.mask, 4'b1000); end
        tick();
        tests++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL tmo_pulse_width: got %b expected %b", TIMEOUT_ERR, 1'b0); end
        tests++; if (BG !== 4'd0 || BUS_IDLE !== 1'b1) begin fails++; $display("FAIL tmo_masked_idle: got %b/%b expected 0000/1", BG, BUS_IDLE); end
        tick();
        tick();
        tests++; if (BG !== 4'd0) begin fails++; $display("FAIL tmo_ignored: got %b expected %b", BG, 4'd0); end
        BR = 4'd0;
        tick();
        tests++; if (dut.mask !== 4'd0) begin fails++; $display("FAIL tmo_mask_clear: got %b expected %b", dut.mask, 4'd0); end
        BR = 4'b1000;
        tick();
        tests++; if (BG !== 4'b1000) begin fails++; $display("FAIL tmo_regrant: got %b expected %b", BG, 4'b1000); end
        BR = 4'd0;
        tick();
        tick();
    endtask

    task automatic test_ack_keepalive;
        int held;
        int pulses;
        BR = 4'b0001;
        tick();
        held   = 0;
        pulses = 0;
        for (int c = 1; c <= 200; c++) begin
            ACK = (c % 10 == 0);
            tick();
            if (BG === 4'b0001) held++;
            if (TIMEOUT_ERR === 1'b1) pulses++;
        end
        ACK = 1'b0;
        tests++; if (held != 200) begin fails++; $display("FAIL ack_held: got %0d expected %0d", held, 200); end
        tests++; if (pulses != 0) begin fails++; $display("FAIL ack_no_timeout: got %0d expected %0d", pulses, 0); end
        BR = 4'd0;
        tick();
        tick();
    endtask

    task automatic test_release_at_timeout;
        ACK = 1'b0;
        BR  = 4'b0100;
        tick();
        for (int c = 0; c < 63; c++) tick();
        tests++; if (dut.wdog !== 8'd63 || BG !== 4'b0100) begin fails++; $display("FAIL rel_align: got wdog=%0d bg=%b expected 63/0100", dut.wdog, BG); end
        BR = 4'd0;
        tick();
        tests++; if (TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL rel_no_pulse: got %b expected %b", TIMEOUT_ERR, 1'b0); end
        tests++; if (dut.mask !== 4'd0 || BG !== 4'd0) begin fails++; $display("FAIL rel_mask: got mask=%b bg=%b expected 0000/0000", dut.mask, BG); end
        tick();
        tests++; if (BUS_IDLE !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin fails++; $display("FAIL rel_idle: got %b/%b expected 1/0", BUS_IDLE, TIMEOUT_ERR); end
    endtask

    task automatic test_async_reset;
        BR = 4'b0010;
        tick();
        tests++; if (BG !== 4'b0010) begin fails++; $display("FAIL ar_pre_grant: got %b expected %b", BG, 4'b0010); end
        #3;
        RST = 1'b1;
        #1;
        tests++; if (BG !== 4'd0 || OWNER_VLD !== 1'b0) begin fails++; $display("FAIL ar_async_bg: got %b/%b expected 0000/0", BG, OWNER_VLD); end
        tests++; if (OWNER !== 2'd0 || BUS_IDLE !== 1'b1) begin fails++; $display("FAIL ar_async_state: got owner=%0d idle=%b expected 0/1", OWNER, BUS_IDLE); end
        tests++; if (dut.ptr !== 2'd0) begin fails++; $display("FAIL ar_ptr: got %0d expected %0d", dut.ptr, 0); end
        tick();
        RST = 1'b0;
        BR  = 4'b1000;
        tick();
        tests++; if (BG !== 4'b1000 || OWNER !== 2'd3) begin fails++; $display("FAIL ar_regrant: got %b/%0d expected 1000/3", BG, OWNER); end
        BR = 4'd0;
        tick();
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        RST   = 1'b1;
        BR    = 4'd0;
        ACK   = 1'b0;
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_ack_keepalive();
        test_release_at_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 64: max consecutive GRANT cycles without ACK before forced revoke (legal 2..255).
REQ-002 SHALL have parameter TURN_CYC, default 1: bus turnaround cycles between owners (legal 1..3).
REQ-003 SHALL have port BUS_CLK  input  1  bus clock, sole clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port BR  input  4  bus requests; BR[i] held high by controller i for its whole ownership.
REQ-006 SHALL have port ACK  input  1  bus acknowledge line, observed only.
REQ-007 SHALL have port BG  output  4  bus grants, one-hot or zero, registered.
REQ-008 SHALL have port OWNER  output  2  index of current grantee, registered.
REQ-009 SHALL have port OWNER_VLD  output  1  high exactly when BG != 0.
REQ-010 SHALL have port BUS_IDLE  output  1  high in state IDLE.
REQ-011 SHALL have port TIMEOUT_ERR  output  1  one-cycle pulse on forced revoke.

Function
REQ-012 SHALL implement one-hot states IDLE, GRANT, TURN; all outputs driven from registers.
REQ-013 SHALL keep a 2-bit priority pointer PTR; requester PTR highest, then PTR+1, PTR+2, PTR+3 (mod 4).
REQ-014 SHALL keep a 4-bit MASK; eligible[i] = BR[i] & ~MASK[i].
REQ-015 IDLE: on an edge with any eligible request, SHALL go to GRANT, set BG[w] and OWNER=w for winner w; BG visible one cycle after BR first sampled high.
REQ-016 IDLE with no eligible request SHALL remain IDLE with BG=0.
REQ-017 On every grant to w, SHALL set PTR = w+1 mod 4 (wrap 3->0).
REQ-018 GRANT: while BR[OWNER]=1 and no timeout, SHALL hold BG and OWNER unchanged regardless of other BR.
REQ-019 GRANT: on an edge with BR[OWNER]=0, SHALL clear BG and enter TURN.
REQ-020 SHALL count 8-bit WDOG in GRANT: cleared on grant and on any cycle with ACK=1, else incremented.
REQ-021 When WDOG = HOLD_MAX-1 and ACK=0 and BR[OWNER]=1, SHALL clear BG, set MASK[OWNER], pulse TIMEOUT_ERR, enter TURN.
REQ-022 If BR[OWNER] drops in the same cycle the timeout fires, SHALL treat it as normal release: no TIMEOUT_ERR, no mask.
REQ-023 SHALL clear MASK[i] on any edge with BR[i] sampled low.
REQ-024 TURN: SHALL hold BG=0 for exactly TURN_CYC cycles, then arbitrate as in REQ-015 (go to GRANT directly if eligible request, else IDLE).
REQ-025 SHALL never assert two BG bits simultaneously, nor BG in consecutive cycles to different owners without a TURN gap.
REQ-026 OWNER SHALL retain last grantee value while OWNER_VLD=0.

Reset
REQ-027 RST high SHALL immediately force BG=0, OWNER=0, OWNER_VLD=0, TIMEOUT_ERR=0, BUS_IDLE=1, state IDLE, PTR=0, MASK=0, WDOG=0.
REQ-028 Reset asserted during GRANT SHALL revoke the grant without a TURN period; first grant after RST release follows REQ-015 with PTR=0.

Verification
REQ-029 BR=4'b0110 from IDLE after reset -> BG=4'b0010 next cycle, PTR=2; BR[1] drops -> BG=0 for 1 cycle, then BG=4'b0100.
REQ-030 All BR held high continuously, each owner releasing after 3 cycles and re-requesting -> grant order 0,1,2,3,0 with 1-cycle gaps.
REQ-031 BR[3] held, ACK=0, HOLD_MAX=64 -> BG[3] drops after 64 GRANT cycles, TIMEOUT_ERR one pulse, BR[3] ignored until it goes low and high again.
REQ-032 ACK pulsed every 10 cycles during a 200-cycle ownership -> no timeout, BG held throughout.
REQ-033 BR[OWNER] drop coincides with WDOG=HOLD_MAX-1 -> TIMEOUT_ERR stays 0, MASK unchanged.
REQ-034 RST asserted mid-GRANT between clock edges -> BG=0 without waiting for BUS_CLK; after release BR=4'b1000 -> BG=4'b1000.
